mux_scan_capture: RTL and testbench

- Sequential counterpart to the switch-select mux.
- Drives the 3-bit select of an external 8:1 mux, waits for the mux output to settle on each channel, and samples the single-bit mux output.
- Assembles the eight samples into a parallel byte and publishes it with a one-cycle valid pulse.
- Sits between the switch mux and the LED/display logic, turning the time-multiplexed single bit back into a parallel word.

---
 rtl/mux_scan_capture.sv | 143 ++++++++++++++
 tb/tb_mux_scan_capture.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mux_scan_capture.sv
`default_nettype none
// ============================================================================
// Module   : mux_scan_capture
// Purpose  : Walks the select lines of an external 2**SEL_W:1 mux. It waits
//            SETTLE_CYCLES on each channel so the mux output can settle, then
//            samples the single-bit mux output. The samples are collected
//            into a parallel word, which is published with a one-cycle valid
//            pulse.
// Ports    : clk    - system clock, rising edge
//            rst_n  - asynchronous active-low reset
//            start  - request one scan frame (looked at only while idle)
//            cont   - continuous mode, looked at only at the end of a frame
//            din    - mux output bit
//            sel    - mux select drive
//            dout   - last completed frame, bit i = sample taken with sel=i
//            valid  - one-cycle pulse when dout updates
//            busy   - high whenever a frame is in progress
// Revision : 1.0 - initial release
// ============================================================================
module mux_scan_capture #(
  parameter int SETTLE_CYCLES = 4,
  parameter int SEL_W         = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               cont,
  input  logic               din,
  output logic [SEL_W-1:0]   sel,
  output logic [2**SEL_W-1:0] dout,
  output logic               valid,
  output logic               busy
);

  localparam int N     = 2**SEL_W;
  // SETTLE_CYCLES is limited to 1..15, so a 4-bit counter covers it.
  localparam int CNT_W = 4;

  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [SEL_W-1:0] SEL_LAST    = SEL_W'(N - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t           state, state_nxt;
  logic [SEL_W-1:0] sel_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [N-1:0]     shadow, shadow_nxt;
  logic [N-1:0]     dout_nxt;
  logic             valid_nxt;

  // --------------------------------------------------------------------------
  // State and datapath registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      sel    <= '0;
      cnt    <= '0;
      shadow <= '0;
      dout   <= '0;
      valid  <= 1'b0;
    end else begin
      state  <= state_nxt;
      sel    <= sel_nxt;
      cnt    <= cnt_nxt;
      shadow <= shadow_nxt;
      dout   <= dout_nxt;
      valid  <= valid_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state and datapath logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_nxt  = state;
    sel_nxt    = sel;
    cnt_nxt    = cnt;
    shadow_nxt = shadow;
    dout_nxt   = dout;
    valid_nxt  = 1'b0;

    unique case (state)
      IDLE: begin
        // A start request launches a frame. cont alone does not.
        if (start) begin
          state_nxt = SETTLE;
          sel_nxt   = '0;
          cnt_nxt   = '0;
        end
      end

      SETTLE: begin
        // sel stays put. The counter only measures how long it has been
        // stable. It stops at the last value instead of wrapping.
        if (cnt == SETTLE_LAST) begin
          state_nxt = SAMPLE;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end

      SAMPLE: begin
        // The only cycle in which din is captured for this channel.
        shadow_nxt[sel] = din;
        if (sel == SEL_LAST) begin
          state_nxt = DONE;
        end else begin
          sel_nxt   = sel + 1'b1;
          cnt_nxt   = '0;
          state_nxt = SETTLE;
        end
      end

      DONE: begin
        // The whole frame is published at once, so a partial frame never
        // appears on dout.
        dout_nxt  = shadow;
        valid_nxt = 1'b1;
        sel_nxt   = '0;
        if (cont) begin
          state_nxt = SETTLE;
          cnt_nxt   = '0;
        end else begin
          state_nxt = IDLE;
        end
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  assign busy = (state != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_mux_scan_capture.sv
`default_nettype none
// ============================================================================
// Module   : tb_mux_scan_capture
// Purpose  : Self-checking bench for mux_scan_capture. It models the external
//            mux as din = pattern[sel], optionally corrupted by noise outside
//            the sample cycle. The expected sel, busy, valid and dout values
//            are computed from frame and channel timing arithmetic.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mux_scan_capture;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       cont;
  logic [7:0] pattern;
  logic       noise;
  logic       use_b;

  logic       start_a, cont_a, din_a, valid_a, busy_a;
  logic [2:0] sel_a;
  logic [7:0] dout_a;
  logic       start_b, cont_b, din_b, valid_b, busy_b;
  logic [2:0] sel_b;
  logic [7:0] dout_b;

  logic [2:0] m_sel;
  logic [7:0] m_dout;
  logic       m_valid, m_busy;

  int         checks;
  int         errors;
  logic [7:0] last_dout;

  assign start_a = start & ~use_b;
  assign cont_a  = cont  & ~use_b;
  assign start_b = start &  use_b;
  assign cont_b  = cont  &  use_b;
  assign din_a   = pattern[sel_a] ^ noise;
  assign din_b   = pattern[sel_b] ^ noise;

  assign m_sel   = use_b ? sel_b   : sel_a;
  assign m_dout  = use_b ? dout_b  : dout_a;
  assign m_valid = use_b ? valid_b : valid_a;
  assign m_busy  = use_b ? busy_b  : busy_a;

  mux_scan_capture #(.SETTLE_CYCLES(4), .SEL_W(3)) dut_a (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start_a),
    .cont  (cont_a),
    .din   (din_a),
    .sel   (sel_a),
    .dout  (dout_a),
    .valid (valid_a),
    .busy  (busy_a)
  );

  mux_scan_capture #(.SETTLE_CYCLES(1), .SEL_W(3)) dut_b (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start_b),
    .cont  (cont_b),
    .din   (din_b),
    .sel   (sel_b),
    .dout  (dout_b),
    .valid (valid_b),
    .busy  (busy_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog expired got timeout required finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Runs one scan launch and checks every cycle against the timing model.
  // Cycle c counts from the edge on which start is seen (c=1 is the first
  // cycle after that edge). A channel lasts s+1 cycles, and a frame lasts
  // 8*(s+1)+1 cycles including DONE.
  task automatic scan_check(input string name, input int s,
                            input logic [7:0] pat0, input logic [7:0] pat1,
                            input logic [7:0] prev, input bit use_cont,
                            input int drop_at, input bit restarts,
                            input bit noisy, input int ncycles);
    int         per, span, nf, k, r;
    bit         samp;
    logic       exp_busy, exp_valid;
    logic [2:0] exp_sel;
    logic [7:0] exp_dout;
    per      = 8 * (s + 1) + 1;
    span     = 8 * (s + 1);
    nf       = use_cont ? ((drop_at - 1) / per + 1) : 1;
    exp_dout = prev;
    pattern  = pat0;
    noise    = 1'b0;
    cont     = use_cont;
    start    = 1'b1;
    tick();
    start    = 1'b0;
    for (int c = 1; c <= ncycles; c++) begin
      k = (c - 1) / per;
      r = (c - 1) % per;
      if (use_cont && c >= drop_at) cont = 1'b0;
      pattern = (c > per) ? pat1 : pat0;
      start   = restarts && (c == 10 || c == 30);
      samp    = (k < nf) && (r < span) && ((r % (s + 1)) == s);
      noise   = (noisy && !samp) ? 1'($urandom_range(0, 1)) : 1'b0;
      exp_busy  = (k < nf);
      exp_sel   = (k < nf) ? ((r < span) ? 3'(r / (s + 1)) : 3'd7) : 3'd0;
      exp_valid = (r == 0) && (k >= 1) && (k <= nf);
      if (exp_valid) exp_dout = (k == 1) ? pat0 : pat1;
      checks++;
      if (m_busy !== exp_busy) begin
        errors++;
        $display("FAIL %s busy cycle %0d got %b exp %b", name, c, m_busy, exp_busy);
      end
      checks++;
      if (m_sel !== exp_sel) begin
        errors++;
        $display("FAIL %s sel cycle %0d got %0d exp %0d", name, c, m_sel, exp_sel);
      end
      checks++;
      if (m_valid !== exp_valid) begin
        errors++;
        $display("FAIL %s valid cycle %0d got %b exp %b", name, c, m_valid, exp_valid);
      end
      checks++;
      if (m_dout !== exp_dout) begin
        errors++;
        $display("FAIL %s dout cycle %0d got %h exp %h", name, c, m_dout, exp_dout);
      end
      tick();
    end
    start     = 1'b0;
    cont      = 1'b0;
    noise     = 1'b0;
    last_dout = exp_dout;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    for (int i = 0; i < 4; i++) begin
      start = 1'($urandom_range(0, 1));
      cont  = 1'($urandom_range(0, 1));
      noise = 1'($urandom_range(0, 1));
      tick();
    end
    start = 1'b0;
    cont  = 1'b0;
    noise = 1'b0;
    rst_n = 1'b1;
    tick();
    checks++;
    if ({m_sel, m_dout, m_valid, m_busy} !== 13'd0) begin
      errors++;
      $display("FAIL reset_release got sel=%0d dout=%h valid=%b busy=%b exp all 0",
               m_sel, m_dout, m_valid, m_busy);
    end
    // Async assertion between edges, while sel is already non-zero.
    pattern = 8'hFF;
    start   = 1'b1;
    tick();
    start   = 1'b0;
    for (int i = 0; i < 7; i++) tick();
    #3 rst_n = 1'b0;
    #1;
    checks++;
    if ({m_sel, m_dout, m_valid, m_busy} !== 13'd0) begin
      errors++;
      $display("FAIL reset_async got sel=%0d dout=%h valid=%b busy=%b exp all 0",
               m_sel, m_dout, m_valid, m_busy);
    end
    tick();
    rst_n     = 1'b1;
    last_dout = 8'h00;
    tick();
  endtask

  task automatic test_single_frame();
    scan_check("single", 4, 8'hA5, 8'hA5, last_dout, 1'b0, 0, 1'b0, 1'b0, 50);
  endtask

  task automatic test_busy_start();
    scan_check("busy_start", 4, 8'h5A, 8'h5A, last_dout, 1'b0, 0, 1'b1, 1'b0, 50);
  endtask

  task automatic test_settle_immunity();
    scan_check("settle_noise", 4, 8'h3C, 8'h3C, last_dout, 1'b0, 0, 1'b0, 1'b1, 50);
  endtask

  task automatic test_reset_mid_frame();
    scan_check("pre_ff", 4, 8'hFF, 8'hFF, last_dout, 1'b0, 0, 1'b0, 1'b0, 45);
    pattern = 8'h00;
    start   = 1'b1;
    tick();
    start   = 1'b0;
    for (int c = 1; c < 20; c++) tick();
    rst_n = 1'b0;
    #1;
    checks++;
    if ({m_sel, m_dout, m_valid, m_busy} !== 13'd0) begin
      errors++;
      $display("FAIL reset_mid got sel=%0d dout=%h valid=%b busy=%b exp all 0",
               m_sel, m_dout, m_valid, m_busy);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (m_valid !== 1'b0 || m_dout !== 8'h00) begin
        errors++;
        $display("FAIL reset_hold got valid=%b dout=%h exp 0 00", m_valid, m_dout);
      end
    end
    rst_n     = 1'b1;
    last_dout = 8'h00;
    tick();
    scan_check("post_reset", 4, 8'($urandom), 8'h00, last_dout,
               1'b0, 0, 1'b0, 1'b1, 48);
  endtask

  task automatic test_continuous();
    scan_check("cont", 4, 8'h12, 8'h34, last_dout, 1'b1, 100, 1'b0, 1'b0, 140);
  endtask

  task automatic test_cont_alone();
    cont = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      checks++;
      if (m_busy !== 1'b0 || m_valid !== 1'b0) begin
        errors++;
        $display("FAIL cont_alone got busy=%b valid=%b exp 0 0", m_busy, m_valid);
      end
    end
    cont = 1'b0;
    tick();
  endtask

  task automatic test_random();
    for (int i = 0; i < 4; i++) begin
      scan_check("random", 4, 8'($urandom), 8'h00, last_dout, 1'b0, 0,
                 1'($urandom_range(0, 1)), 1'b1, 44);
    end
  endtask

  task automatic test_param_variant();
    use_b     = 1'b1;
    last_dout = 8'h00;
    tick();
    scan_check("param_s1", 1, 8'h81, 8'h81, last_dout, 1'b0, 0, 1'b0, 1'b1, 24);
    use_b = 1'b0;
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    rst_n     = 1'b0;
    start     = 1'b0;
    cont      = 1'b0;
    pattern   = 8'h00;
    noise     = 1'b0;
    use_b     = 1'b0;
    last_dout = 8'h00;
    test_reset();
    test_single_frame();
    test_busy_start();
    test_settle_immunity();
    test_reset_mid_frame();
    test_continuous();
    test_cont_alone();
    test_random();
    test_param_variant();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
